// File: rtl/cdma_stripe_req_split.sv
// Striped card-memory read command splitter.
// Splits one striped read request into chunks of at most CHUNK_BEATS beats.
// For each chunk it emits one mux command, then one read command per channel
// that the chunk touches, in ascending channel order.
module cdma_stripe_req_split #(
    parameter int N_MEM_CHAN  = 4,
    parameter int DATA_BITS   = 512,
    parameter int ADDR_BITS   = 48,
    parameter int LEN_BITS    = 28,
    parameter int CHUNK_BEATS = 64
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_req_valid,
    output logic                            s_req_ready,
    input  logic [ADDR_BITS-1:0]            s_req_addr,
    input  logic [LEN_BITS-1:0]             s_req_len,
    input  logic                            s_req_ctl,
    output logic                            m_mux_valid,
    input  logic                            m_mux_ready,
    output logic [$clog2(N_MEM_CHAN)-1:0]   m_mux_sel,
    output logic [LEN_BITS-$clog2(DATA_BITS/8)-1:0] m_mux_len,
    output logic                            m_mux_ctl,
    output logic [N_MEM_CHAN-1:0]           m_card_valid,
    input  logic [N_MEM_CHAN-1:0]           m_card_ready,
    output logic [N_MEM_CHAN*ADDR_BITS-1:0] m_card_addr,
    output logic [N_MEM_CHAN*LEN_BITS-1:0]  m_card_len
);

    localparam int BL        = $clog2(DATA_BITS / 8);
    localparam int LN        = $clog2(N_MEM_CHAN);
    localparam int BEAT_BITS = LEN_BITS - BL;
    localparam int BW        = BEAT_BITS + 1;
    localparam int GBITS     = ADDR_BITS - BL;
    localparam logic [BW-1:0] CHUNK = BW'(CHUNK_BEATS);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_MUX, ST_ISSUE} state_t;

    state_t                          r_state, w_next;
    logic [GBITS-1:0]                r_g0;
    logic [BEAT_BITS-1:0]            r_brem;
    logic                            r_ctl;
    logic [BW-1:0]                   r_bc;
    logic                            r_last;
    logic [LN-1:0]                   r_k;
    logic [LN-1:0]                   r_mux_sel;
    logic [BEAT_BITS-1:0]            r_mux_len;
    logic                            r_mux_ctl;
    logic [N_MEM_CHAN-1:0]           r_nz;
    logic [N_MEM_CHAN*ADDR_BITS-1:0] r_card_addr;
    logic [N_MEM_CHAN*LEN_BITS-1:0]  r_card_len;

    logic [BEAT_BITS-1:0]            w_req_beats;
    logic                            w_req_hs;
    logic                            w_issue_adv;
    logic                            w_issue_done;
    logic [BW-1:0]                   w_brem_x;
    logic [BW-1:0]                   w_bc;
    logic                            w_last;
    logic [LN-1:0]                   w_start;
    logic [GBITS-LN-1:0]             w_base;
    logic [LN-1:0]                   w_d     [N_MEM_CHAN];
    logic [BW-1:0]                   w_beats [N_MEM_CHAN];
    logic [GBITS-1:0]                w_local [N_MEM_CHAN];
    logic [N_MEM_CHAN-1:0]           w_nz;
    logic [N_MEM_CHAN*ADDR_BITS-1:0] w_addr;
    logic [N_MEM_CHAN*LEN_BITS-1:0]  w_len;

    assign w_req_beats = s_req_len[LEN_BITS-1:BL];
    assign w_brem_x    = {1'b0, r_brem};
    assign w_bc        = (w_brem_x > CHUNK) ? CHUNK : w_brem_x;
    assign w_last      = (w_brem_x == w_bc);
    assign w_start     = r_g0[LN-1:0];
    assign w_base      = r_g0[GBITS-1:LN];

    // State register.
    always_ff @(posedge aclk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next       = r_state;
        s_req_ready  = 1'b0;
        m_mux_valid  = 1'b0;
        m_card_valid = '0;
        w_req_hs     = 1'b0;
        w_issue_adv  = 1'b0;
        w_issue_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_req_ready = !areset;
                if (s_req_valid && !areset) begin
                    w_req_hs = 1'b1;
                    if (w_req_beats != '0) w_next = ST_CALC;
                end
            end
            ST_CALC: w_next = ST_MUX;
            ST_MUX: begin
                m_mux_valid = 1'b1;
                if (m_mux_ready) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_card_valid[r_k] = r_nz[r_k];
                w_issue_adv       = !r_nz[r_k] || m_card_ready[r_k];
                if (w_issue_adv && (r_k == LN'(N_MEM_CHAN - 1))) begin
                    w_issue_done = 1'b1;
                    w_next       = r_last ? ST_IDLE : ST_CALC;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Per-channel beat count and local address for the current chunk.
    always_comb begin
        w_nz   = '0;
        w_addr = '0;
        w_len  = '0;
        for (int c = 0; c < N_MEM_CHAN; c++) begin
            w_d[c]     = LN'(c) - w_start;
            w_beats[c] = (w_bc > BW'(w_d[c]))
                         ? (((w_bc - BW'(w_d[c]) - BW'(1)) >> LN) + BW'(1))
                         : '0;
            // Channels below the start channel are already one stripe row further on.
            w_local[c] = GBITS'(w_base) + GBITS'(LN'(c) < w_start);
            w_nz[c]    = (w_beats[c] != '0);
            w_addr[c*ADDR_BITS +: ADDR_BITS] = {w_local[c], {BL{1'b0}}};
            w_len[c*LEN_BITS +: LEN_BITS]    = {w_beats[c][BEAT_BITS-1:0], {BL{1'b0}}};
        end
    end

    // Request, chunk and channel-command registers.
    always_ff @(posedge aclk) begin
        // NOTE: datapath registers are reset too, because every output must read 0 while in reset.
        if (areset) begin
            r_g0        <= '0;
            r_brem      <= '0;
            r_ctl       <= 1'b0;
            r_bc        <= '0;
            r_last      <= 1'b0;
            r_k         <= '0;
            r_mux_sel   <= '0;
            r_mux_len   <= '0;
            r_mux_ctl   <= 1'b0;
            r_nz        <= '0;
            r_card_addr <= '0;
            r_card_len  <= '0;
        end else begin
            if (w_req_hs) begin
                r_g0   <= s_req_addr[ADDR_BITS-1:BL];
                r_brem <= w_req_beats;
                r_ctl  <= s_req_ctl;
            end
            if (r_state == ST_CALC) begin
                r_bc        <= w_bc;
                r_last      <= w_last;
                r_mux_sel   <= w_start;
                r_mux_len   <= BEAT_BITS'(w_bc - BW'(1));
                r_mux_ctl   <= r_ctl & w_last;
                r_nz        <= w_nz;
                r_card_addr <= w_addr;
                r_card_len  <= w_len;
            end
            if (r_state == ST_MUX && m_mux_ready) r_k <= '0;
            if (w_issue_adv) r_k <= r_k + LN'(1);
            if (w_issue_done) begin
                r_brem <= r_brem - BEAT_BITS'(r_bc);
                r_g0   <= r_g0 + GBITS'(r_bc);
            end
        end
    end

    assign m_mux_sel   = r_mux_sel;
    assign m_mux_len   = r_mux_len;
    assign m_mux_ctl   = r_mux_ctl;
    assign m_card_addr = r_card_addr;
    assign m_card_len  = r_card_len;

endmodule
